count_threshold_mon: RTL and testbench

//  Downstream consumer of the free-running 8-bit count driven by the bug

---
 rtl/count_threshold_mon.sv | 195 +++++++++++++++++++
 tb/tb_count_threshold_mon.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_threshold_mon.sv
// ---------------------------------------------------------------------------
// count_threshold_mon
//
// Watches the free-running count from the upstream counter stage and reports
// debounced strict threshold crossings (in_value > thresh). A crossing has to
// hold for HOLD_CYCLES consecutive valid samples before it is accepted. When
// it is accepted the block emits a one-cycle trigger pulse, captures the
// sample that completed qualification and counts the event. A sticky flag
// records any backwards step of the sampled count (a wrap-around).
//
// Parameters
//   WIDTH        width of the sampled count and of the threshold (unsigned)
//   HOLD_CYCLES  consecutive qualifying valid samples before a trigger (1..255)
//   EVT_CNT_W    width of the crossing-event counter
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active-high
//   enable      in   0 forces IDLE; 1 arms the monitor
//   clear       in   synchronous clear of evt_count and wrap_seen
//   in_valid    in   in_value carries a new sample this cycle
//   in_value    in   sampled count from the upstream counter
//   thresh      in   threshold, compared as in_value > thresh
//   above       out  level, high while the FSM is in ABOVE
//   trig_pulse  out  one-cycle pulse on entry to ABOVE
//   trig_value  out  sample that completed qualification, held until the next trigger
//   evt_count   out  number of triggers since reset or clear
//   wrap_seen   out  sticky, a valid sample was lower than the previous valid sample
//   state_o     out  FSM state (IDLE=0, BELOW=1, PEND=2, ABOVE=3)
//
// Build option
//   CTM_EVT_SATURATE_EN  when defined, evt_count saturates at all-ones
//                        instead of wrapping modulo 2^EVT_CNT_W.
// ---------------------------------------------------------------------------
module count_threshold_mon #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int EVT_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_value,
    input  logic [WIDTH-1:0]     thresh,
    output logic                 above,
    output logic                 trig_pulse,
    output logic [WIDTH-1:0]     trig_value,
    output logic [EVT_CNT_W-1:0] evt_count,
    output logic                 wrap_seen,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BELOW = 2'd1,
        PEND  = 2'd2,
        ABOVE = 2'd3
    } state_t;

    // Hold counter is 8 bits because HOLD_CYCLES is at most 255.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES);

    state_t                 state_reg;
    logic [7:0]             hold_reg;
    logic [WIDTH-1:0]       prev_reg;
    logic                   prev_ok_reg;
    logic                   above_reg;
    logic                   trig_pulse_reg;
    logic [WIDTH-1:0]       trig_value_reg;
    logic [EVT_CNT_W-1:0]   evt_count_reg;
    logic                   wrap_seen_reg;

    logic                   is_above;
    logic                   is_wrap;
    logic [7:0]             hold_inc;
    logic                   trig_fire;
    logic [EVT_CNT_W-1:0]   evt_count_inc;

    assign is_above = in_value > thresh;
    assign is_wrap  = in_valid && prev_ok_reg && (in_value < prev_reg);
    assign hold_inc = hold_reg + 8'd1;

    // Hold is zero in BELOW, so the same "hold+1 reaches the limit" test
    // covers both the HOLD_CYCLES=1 direct jump and the end of PEND.
    assign trig_fire = enable && in_valid && is_above &&
                       ((state_reg == BELOW) || (state_reg == PEND)) &&
                       (hold_inc == HOLD_LAST);

`ifdef CTM_EVT_SATURATE_EN
    assign evt_count_inc = (&evt_count_reg) ? evt_count_reg : evt_count_reg + 1'b1;
`else
    assign evt_count_inc = evt_count_reg + 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            prev_reg       <= '0;
            prev_ok_reg    <= 1'b0;
            above_reg      <= 1'b0;
            trig_pulse_reg <= 1'b0;
            trig_value_reg <= '0;
            evt_count_reg  <= '0;
            wrap_seen_reg  <= 1'b0;
        end else begin
            trig_pulse_reg <= trig_fire;
            if (trig_fire) begin
                trig_value_reg <= in_value;
            end

            // clear has priority over a same-cycle increment or wrap.
            if (clear) begin
                evt_count_reg <= '0;
            end else if (trig_fire) begin
                evt_count_reg <= evt_count_inc;
            end

            if (clear) begin
                wrap_seen_reg <= 1'b0;
            end else if (is_wrap) begin
                wrap_seen_reg <= 1'b1;
            end

            // Wrap history tracks every valid sample, whatever the FSM does.
            if (in_valid) begin
                prev_reg    <= in_value;
                prev_ok_reg <= 1'b1;
            end

            if (!enable) begin
                state_reg <= IDLE;
                hold_reg  <= '0;
                above_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        // Arming cycle: the sample present now is not evaluated.
                        state_reg <= BELOW;
                        hold_reg  <= '0;
                    end
                    BELOW: begin
                        if (in_valid && is_above) begin
                            if (trig_fire) begin
                                state_reg <= ABOVE;
                                above_reg <= 1'b1;
                                hold_reg  <= '0;
                            end else begin
                                state_reg <= PEND;
                                hold_reg  <= 8'd1;
                            end
                        end
                    end
                    PEND: begin
                        if (in_valid) begin
                            if (is_above) begin
                                if (trig_fire) begin
                                    state_reg <= ABOVE;
                                    above_reg <= 1'b1;
                                    hold_reg  <= '0;
                                end else begin
                                    hold_reg <= hold_inc;
                                end
                            end else begin
                                state_reg <= BELOW;
                                hold_reg  <= '0;
                            end
                        end
                    end
                    ABOVE: begin
                        if (in_valid && !is_above) begin
                            state_reg <= BELOW;
                            above_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        hold_reg  <= '0;
                        above_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign above      = above_reg;
    assign trig_pulse = trig_pulse_reg;
    assign trig_value = trig_value_reg;
    assign evt_count  = evt_count_reg;
    assign wrap_seen  = wrap_seen_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_count_threshold_mon.sv
// ---------------------------------------------------------------------------
// tb_count_threshold_mon
//
// Directed scenarios followed by a randomized run. A behavioural model tracks
// the monitor as "armed or not" plus the length of the current run of valid
// samples above threshold; state and trigger expectations are derived from
// that run length. Every cycle all outputs are compared with the model.
// The DUT uses a 2-bit event counter so wrap/saturation is reachable.
// ---------------------------------------------------------------------------
module tb_count_threshold_mon;

    localparam int HOLD = 4;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clear;
    logic          in_valid;
    logic [7:0]    in_value;
    logic [7:0]    thresh;
    logic          above;
    logic          trig_pulse;
    logic [7:0]    trig_value;
    logic [CW-1:0] evt_count;
    logic          wrap_seen;
    logic [1:0]    state_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    bit m_armed;
    int m_run;
    bit m_pulse;
    int m_tv;
    int m_cnt;
    bit m_wrap;
    int m_prev;
    bit m_prev_ok;

    count_threshold_mon #(
        .WIDTH      (8),
        .HOLD_CYCLES(HOLD),
        .EVT_CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_value  (in_value),
        .thresh    (thresh),
        .above     (above),
        .trig_pulse(trig_pulse),
        .trig_value(trig_value),
        .evt_count (evt_count),
        .wrap_seen (wrap_seen),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_run = 0; m_pulse = 0; m_tv = 0;
        m_cnt = 0; m_wrap = 0; m_prev = 0; m_prev_ok = 0;
    endtask

    function automatic int exp_state();
        if (!m_armed)        return 0;
        else if (m_run == 0) return 1;
        else if (m_run < HOLD) return 2;
        else                 return 3;
    endfunction

    task automatic model_update(input bit e, input bit c, input bit v, input int val, input int th);
        m_pulse = 0;
        if (v && m_prev_ok && val < m_prev) m_wrap = 1;
        if (v) begin
            m_prev = val;
            m_prev_ok = 1;
        end
        if (!e) begin
            m_armed = 0;
            m_run = 0;
        end else if (!m_armed) begin
            m_armed = 1;
            m_run = 0;
        end else if (v) begin
            if (val > th) begin
                if (m_run < HOLD) begin
                    m_run++;
                    if (m_run == HOLD) begin
                        m_pulse = 1;
                        m_tv = val;
`ifdef CTM_EVT_SATURATE_EN
                        if (m_cnt < (1 << CW) - 1) m_cnt++;
`else
                        m_cnt = (m_cnt + 1) % (1 << CW);
`endif
                    end
                end
            end else begin
                m_run = 0;
            end
        end
        if (c) begin
            m_cnt = 0;
            m_wrap = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_state"}, 32'(state_o), 32'(exp_state()));
        chk({tag, "_above"}, 32'(above), 32'(exp_state() == 3));
        chk({tag, "_pulse"}, 32'(trig_pulse), 32'(m_pulse));
        chk({tag, "_tval"}, 32'(trig_value), 32'(m_tv));
        chk({tag, "_evt"}, 32'(evt_count), 32'(m_cnt));
        chk({tag, "_wrap"}, 32'(wrap_seen), 32'(m_wrap));
    endtask

    task automatic step(input string tag, input bit e, input bit c, input bit v,
                        input int val, input int th);
        enable   = e;
        clear    = c;
        in_valid = v;
        in_value = 8'(val);
        thresh   = 8'(th);
        @(posedge clk);
        model_update(e, c, v, val, th);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset applied between clock edges.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #2 rst = 1'b0;
    endtask

    initial begin
        int seq2[7];
        int th_r;
        int v_r;
        seq2 = '{6, 7, 3, 6, 7, 8, 9};

        rst = 1'b1; enable = 0; clear = 0; in_valid = 0; in_value = 0; thresh = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // T1: rising ramp 0..10, trigger after sample 9
        step("t1_arm", 1, 0, 0, 0, 5);
        for (int i = 0; i <= 10; i++) begin
            step("t1", 1, 0, 1, i, 5);
            chk("t1_pulse_at", 32'(trig_pulse), 32'(i == 9));
        end
        chk("t1_tval9", 32'(trig_value), 32'd9);
        chk("t1_evt1", 32'(evt_count), 32'd1);

        // T2: aborted PEND then single trigger
        step("t2_drop", 1, 0, 1, 3, 5);
        foreach (seq2[i]) step("t2", 1, 0, 1, seq2[i], 5);
        chk("t2_above", 32'(above), 32'd1);
        chk("t2_tval9", 32'(trig_value), 32'd9);

        // T3: wrap 255 -> 0
        step("t3_clr", 1, 1, 0, 0, 5);
        chk("t3_wrap0", 32'(wrap_seen), 32'd0);
        for (int i = 250; i <= 255; i++) step("t3", 1, 0, 1, i, 5);
        chk("t3_nowrap", 32'(wrap_seen), 32'd0);
        step("t3_zero", 1, 0, 1, 0, 5);
        chk("t3_wrap1", 32'(wrap_seen), 32'd1);
        chk("t3_above0", 32'(above), 32'd0);
        step("t3_one", 1, 0, 1, 1, 5);

        // T4: equal to threshold is not above
        for (int i = 0; i < 8; i++) begin
            step("t4", 1, 0, 1, 5, 5);
            chk("t4_state_below", 32'(state_o), 32'd1);
        end

        // T5: counter wrap / saturation with five triggers
        step("t5_clr", 1, 1, 0, 0, 5);
        for (int k = 0; k < 5; k++) begin
            step("t5_low", 1, 0, 1, 0, 5);
            for (int j = 0; j < HOLD; j++) step("t5_hi", 1, 0, 1, 9, 5);
        end
`ifdef CTM_EVT_SATURATE_EN
        chk("t5_evt_sat", 32'(evt_count), 32'd3);
`else
        chk("t5_evt_wrap", 32'(evt_count), 32'd1);
`endif

        // T6a: reset in PEND with hold=2
        step("t6_low", 1, 0, 1, 0, 5);
        step("t6_p1", 1, 0, 1, 6, 5);
        step("t6_p2", 1, 0, 1, 6, 5);
        chk("t6_pend", 32'(state_o), 32'd2);
        mid_reset();
        chk("t6_rst_state", 32'(state_o), 32'd0);

        // T6b: clear coincident with trigger
        step("t6_arm", 1, 0, 1, 0, 5);
        for (int j = 0; j < HOLD - 1; j++) step("t6_q", 1, 0, 1, 6, 5);
        step("t6_clrtrig", 1, 1, 1, 6, 5);
        chk("t6_clr_pulse", 32'(trig_pulse), 32'd1);
        chk("t6_clr_evt0", 32'(evt_count), 32'd0);

        // enable=0 drops to IDLE, keeps evt/wrap/trig_value
        step("dis", 0, 0, 1, 200, 5);
        chk("dis_idle", 32'(state_o), 32'd0);

        // Randomized run
        th_r = 100;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 24) == 0) th_r = int'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) v_r = int'($urandom_range(0, 255));
            else begin
                v_r = th_r + int'($urandom_range(0, 6)) - 3;
                if (v_r < 0) v_r = 0;
                if (v_r > 255) v_r = 255;
            end
            if ($urandom_range(0, 149) == 0) mid_reset();
            step("rnd", $urandom_range(0, 19) != 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7, v_r, th_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
